// File: rtl/multi_digit_calculator_if.sv
// Scan-code input and display-side outputs of the calculator core.
interface multi_digit_calculator_if #(parameter int W = 8);
    logic [7:0]   scan_code;
    logic         scan_ready;
    logic [W-1:0] disp_value;
    logic         disp_neg;
    logic         error;
    logic         busy;
    logic         result_valid;

    modport master (output scan_code, scan_ready,
                    input  disp_value, disp_neg, error, busy, result_valid);
    modport slave  (input  scan_code, scan_ready,
                    output disp_value, disp_neg, error, busy, result_valid);
endinterface

// File: rtl/multi_digit_calculator.sv
// PS/2 calculator core: multi-digit operands, add/sub/shift-add multiply, result chaining.
// Latency: keys act next cycle; add/sub result 1 cycle after '=', multiply W cycles.
// Backpressure: none; every scan byte is consumed on its strobe (dropped while busy).
module multi_digit_calculator #(
    parameter int DIGITS = 2,
    parameter int W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multi_digit_calculator_if.slave bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int MW = (W > 1) ? $clog2(W) : 1;

    function automatic int unsigned pow10(input int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction
    localparam int unsigned POW10 = pow10(DIGITS);

    typedef enum logic [2:0] {S_OP1, S_OP2, S_CALC, S_DONE, S_ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t         state, state_n;
    op_t            op, op_n, kop;
    logic [W-1:0]   op1, op1_n, op2, op2_n, result, result_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2*W-1:0] acc, acc_n, acc_step;
    logic [MW-1:0]  mcnt, mcnt_n;
    logic [W:0]     sum;
    logic           neg, neg_n, brk, brk_n, rv, rv_n;
    logic           key, is_dig, is_op, is_eq, is_esc;
    logic [3:0]     dval;

    always_comb begin
        is_dig = 1'b1;
        dval   = 4'd0;
        case (bus.scan_code)
            8'h45: dval = 4'd0;
            8'h16: dval = 4'd1;
            8'h1E: dval = 4'd2;
            8'h26: dval = 4'd3;
            8'h25: dval = 4'd4;
            8'h2E: dval = 4'd5;
            8'h36: dval = 4'd6;
            8'h3D: dval = 4'd7;
            8'h3E: dval = 4'd8;
            8'h46: dval = 4'd9;
            default: is_dig = 1'b0;
        endcase
    end

    assign is_op  = (bus.scan_code == 8'h55) || (bus.scan_code == 8'h4E) || (bus.scan_code == 8'h7C);
    assign kop    = (bus.scan_code == 8'h4E) ? OP_SUB : (bus.scan_code == 8'h7C) ? OP_MUL : OP_ADD;
    assign is_eq  = (bus.scan_code == 8'h5A);
    assign is_esc = (bus.scan_code == 8'h76);
    // Only bytes that survive the break/extended prefix filter act as keys.
    assign key    = bus.scan_ready && !brk && (bus.scan_code != 8'hF0) && (bus.scan_code != 8'hE0);

    assign sum      = {1'b0, op1} + {1'b0, op2};
    assign acc_step = acc + (op2[mcnt] ? ({{W{1'b0}}, op1} << mcnt) : '0);

    always_comb begin
        state_n  = state;
        op_n     = op;
        op1_n    = op1;
        op2_n    = op2;
        cnt_n    = cnt;
        acc_n    = acc;
        mcnt_n   = mcnt;
        result_n = result;
        neg_n    = neg;
        rv_n     = 1'b0;
        brk_n    = brk;
        if (bus.scan_ready) begin
            if (bus.scan_code == 8'hF0)      brk_n = 1'b1;
            else if (bus.scan_code != 8'hE0) brk_n = 1'b0;
        end
        if (key && is_esc && state != S_CALC) begin
            state_n  = S_OP1;
            op_n     = OP_ADD;
            op1_n    = '0;
            op2_n    = '0;
            cnt_n    = '0;
            acc_n    = '0;
            result_n = '0;
            neg_n    = 1'b0;
        end else begin
            case (state)
                S_OP1: if (key) begin
                    if (is_dig) begin
                        if (cnt < CW'(DIGITS)) begin
                            op1_n = op1 * W'(10) + W'(dval);
                            cnt_n = cnt + CW'(1);
                        end else state_n = S_ERR;
                    end else if (is_op && cnt != '0) begin
                        op_n    = kop;
                        cnt_n   = '0;
                        op2_n   = '0;
                        state_n = S_OP2;
                    end else state_n = S_ERR;
                end
                S_OP2: if (key) begin
                    if (is_dig) begin
                        if (cnt < CW'(DIGITS)) begin
                            op2_n = op2 * W'(10) + W'(dval);
                            cnt_n = cnt + CW'(1);
                        end else state_n = S_ERR;
                    end else if (is_eq && cnt != '0) begin
                        acc_n   = '0;
                        mcnt_n  = '0;
                        state_n = S_CALC;
                    end else state_n = S_ERR;
                end
                S_CALC: case (op)
                    OP_ADD: begin
                        if (sum[W]) state_n = S_ERR;
                        else begin
                            result_n = sum[W-1:0];
                            neg_n    = 1'b0;
                            rv_n     = 1'b1;
                            state_n  = S_DONE;
                        end
                    end
                    OP_SUB: begin
                        neg_n    = (op2 > op1);
                        result_n = (op2 > op1) ? op2 - op1 : op1 - op2;
                        rv_n     = 1'b1;
                        state_n  = S_DONE;
                    end
                    OP_MUL: begin
                        // One multiplier bit per cycle; overflow judged on the final sum.
                        acc_n  = acc_step;
                        mcnt_n = mcnt + MW'(1);
                        if (mcnt == MW'(W - 1)) begin
                            if (acc_step[2*W-1:W] != '0) state_n = S_ERR;
                            else begin
                                result_n = acc_step[W-1:0];
                                neg_n    = 1'b0;
                                rv_n     = 1'b1;
                                state_n  = S_DONE;
                            end
                        end
                    end
                    default: state_n = S_ERR;
                endcase
                S_DONE: if (key) begin
                    if (is_dig) begin
                        op1_n   = W'(dval);
                        cnt_n   = CW'(1);
                        state_n = S_OP1;
                    end else if (is_op) begin
                        if (!neg && 32'(result) < POW10) begin
                            op1_n   = result;
                            op2_n   = '0;
                            cnt_n   = '0;
                            op_n    = kop;
                            state_n = S_OP2;
                        end else state_n = S_ERR;
                    end
                end
                S_ERR: if (key && is_dig) begin
                    op1_n   = W'(dval);
                    cnt_n   = CW'(1);
                    state_n = S_OP1;
                end
                default: state_n = S_OP1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_OP1;
            op     <= OP_ADD;
            op1    <= '0;
            op2    <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcnt   <= '0;
            result <= '0;
            neg    <= 1'b0;
            brk    <= 1'b0;
            rv     <= 1'b0;
        end else begin
            state  <= state_n;
            op     <= op_n;
            op1    <= op1_n;
            op2    <= op2_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            mcnt   <= mcnt_n;
            result <= result_n;
            neg    <= neg_n;
            brk    <= brk_n;
            rv     <= rv_n;
        end
    end

    always_comb begin
        case (state)
            S_OP2:   bus.disp_value = op2;
            S_DONE:  bus.disp_value = result;
            S_ERR:   bus.disp_value = '0;
            default: bus.disp_value = op1;
        endcase
    end
    assign bus.disp_neg     = (state == S_DONE) && neg;
    assign bus.error        = (state == S_ERR);
    assign bus.busy         = (state == S_CALC);
    assign bus.result_valid = rv;
endmodule

// File: tb/tb_multi_digit_calculator.sv
// Directed-vector bench for multi_digit_calculator (DIGITS=2, W=8).
module tb_multi_digit_calculator;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   nbusy, nrv, nrv2;

    always #5 clk = ~clk;

    multi_digit_calculator_if #(.W(8)) bus ();
    multi_digit_calculator #(.DIGITS(2), .W(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    localparam logic [7:0] K0 = 8'h45, K1 = 8'h16, K2 = 8'h1E, K3 = 8'h26, K4 = 8'h25,
                           K5 = 8'h2E, K7 = 8'h3D, K9 = 8'h46, KADD = 8'h55, KSUB = 8'h4E,
                           KMUL = 8'h7C, KEQ = 8'h5A, KESC = 8'h76;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        bus.scan_code  = c;
        bus.scan_ready = 1'b1;
        @(negedge clk);
        bus.scan_ready = 1'b0;
    endtask

    task automatic send_b2b(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.scan_code  = a;
        bus.scan_ready = 1'b1;
        @(negedge clk);
        bus.scan_code  = b;
        @(negedge clk);
        bus.scan_ready = 1'b0;
    endtask

    // Observe a fixed window after '=' (starts at the first CALC cycle).
    task automatic watch(output int busy_n, output int rv_n, output int rv_pairs);
        logic prev = 1'b0;
        busy_n = 0; rv_n = 0; rv_pairs = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.busy) busy_n++;
            if (bus.result_valid) begin
                rv_n++;
                if (prev) rv_pairs++;
            end
            prev = bus.result_valid;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.scan_code  = 8'h00;
        bus.scan_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_disp", bus.disp_value, 0);
        check("rst_err", bus.error, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rv", bus.result_valid, 0);
        reset = 1'b0;

        // 12 + 34 = 46, first two digits on consecutive cycles
        send_b2b(K1, K2);
        check("op1_12", bus.disp_value, 12);
        send(KADD);
        check("op2_start", bus.disp_value, 0);
        send(K3); send(K4);
        check("op2_34", bus.disp_value, 34);
        send(KEQ);
        check("add_busy_now", bus.busy, 1);
        watch(nbusy, nrv, nrv2);
        check("add_busy_cycles", nbusy, 1);
        check("add_rv_count", nrv, 1);
        check("add_rv_consec", nrv2, 0);
        check("add_value", bus.disp_value, 46);
        check("add_neg", bus.disp_neg, 0);

        // 5 - 12 = -7, then operator on negative result -> error
        send(K5); send(KSUB); send(K1); send(K2); send(KEQ);
        watch(nbusy, nrv, nrv2);
        check("sub_value", bus.disp_value, 7);
        check("sub_neg", bus.disp_neg, 1);
        check("sub_rv_count", nrv, 1);
        send(KADD);
        check("neg_chain_err", bus.error, 1);
        check("neg_chain_disp", bus.disp_value, 0);
        check("neg_chain_dneg", bus.disp_neg, 0);

        // 12 * 11 = 132 from ERR via a digit
        send(K1);
        check("err_exit", bus.error, 0);
        check("err_exit_disp", bus.disp_value, 1);
        send(K2); send(KMUL); send(K1); send(K1); send(KEQ);
        watch(nbusy, nrv, nrv2);
        check("mul_busy_cycles", nbusy, 8);
        check("mul_rv_count", nrv, 1);
        check("mul_value", bus.disp_value, 132);

        // 99 * 99 overflows
        send(K9); send(K9); send(KMUL); send(K9); send(K9); send(KEQ);
        watch(nbusy, nrv, nrv2);
        check("mulov_busy", nbusy, 8);
        check("mulov_rv", nrv, 0);
        check("mulov_err", bus.error, 1);

        // Break sequence ignored, E0 prefix passes '='
        send(K7);
        send(8'hF0); send(K7);
        check("brk_op1", bus.disp_value, 7);
        check("brk_err", bus.error, 0);
        send(KADD); send(K2);
        send(8'hE0); send(KEQ);
        watch(nbusy, nrv, nrv2);
        check("ext_eq_value", bus.disp_value, 9);
        check("ext_eq_rv", nrv, 1);

        // Too many digits, Esc, then chaining
        send(K1); send(K2); send(K3);
        check("digits_err", bus.error, 1);
        send(KESC);
        check("esc_err", bus.error, 0);
        check("esc_disp", bus.disp_value, 0);
        send(K4); send(KADD); send(K5); send(KEQ);
        watch(nbusy, nrv, nrv2);
        check("chain_base", bus.disp_value, 9);
        send(KADD);
        check("chain_op2", bus.disp_value, 0);
        check("chain_no_err", bus.error, 0);
        send(K1); send(KEQ);
        watch(nbusy, nrv, nrv2);
        check("chain_value", bus.disp_value, 10);
        send(KEQ);
        check("done_eq_ignored", bus.disp_value, 10);
        send(K0);
        check("done_digit_new", bus.disp_value, 0);

        // Reset in the middle of a multiply, with a coincident strobe
        send(KESC);
        send(K9); send(K9); send(KMUL); send(K2); send(KEQ);
        check("mulrst_busy_pre", bus.busy, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.scan_code  = K1;
        bus.scan_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.scan_ready = 1'b0;
        check("mulrst_busy", bus.busy, 0);
        check("mulrst_disp", bus.disp_value, 0);
        check("mulrst_err", bus.error, 0);
        check("mulrst_neg", bus.disp_neg, 0);
        check("mulrst_rv", bus.result_valid, 0);
        watch(nbusy, nrv, nrv2);
        check("mulrst_no_rv", nrv, 0);
        check("mulrst_no_busy", nbusy, 0);
        send(K3);
        check("post_rst_digit", bus.disp_value, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_digit_calculator.md
# multi_digit_calculator

Parametrised PS/2 calculator core that takes multi-digit decimal operands, supports add, subtract, and sequential multiply, and chains results into the next calculation. It sits between the PS/2 receiver, which supplies `scan_code`/`scan_ready`, and the seven-segment/BCD display logic, which consumes `disp_value`/`disp_neg`/`error`. It filters break and extended prefixes internally and flags overflow and sequence errors.

## Interface
- `DIGITS`, 2: maximum decimal digits per operand; legal only if 10^DIGITS-1 < 2^W.
- `W`, 8: width of operands, result magnitude and display value.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; single clock domain.
- `scan_code`  in  8  PS/2 scan code byte, valid when `scan_ready`=1.
- `scan_ready`  in  1  one-cycle strobe per received byte.
- `disp_value`  out  W  operand being entered or result magnitude.
- `disp_neg`  out  1  result sign, 1 = negative; only set in DONE.
- `error`  out  1  high while in ERR.
- `busy`  out  1  high while in CALC.
- `result_valid`  out  1  one-cycle pulse when a result is registered.

## Operation
- Key decode. Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to 0..9. `+` is 0x55, `-` is 0x4E, `*` is 0x7C, `=` is 0x5A (Enter), clear is 0x76 (Esc). All other codes are "other".
- Prefix filter. 0xF0 sets `brk`; the next byte is discarded and clears `brk`. 0xE0 is discarded and leaves `brk` unchanged. Discarded bytes never change state.
- States: OP1, OP2, CALC, DONE, ERR. Reset state is OP1. Registers op1, op2, cnt, op, acc, result are all cleared to 0.
- OP1:
  - digit with cnt<DIGITS: op1=op1*10+d, cnt++.
  - digit with cnt=DIGITS: ERR.
  - operator with cnt≥1: latch op, cnt=0, op2=0, go to OP2.
  - operator with cnt=0, `=`, or other: ERR.
- OP2: same digit rule into op2.
  - `=` with cnt≥1: go to CALC.
  - `=` with cnt=0, operator, or other: ERR.
- CALC: all bytes, including Esc, are dropped; `brk` tracking continues.
  - `+`: result=op1+op2. Error if the sum is ≥2^W.
  - `-`: if op2>op1, result=op2-op1 and neg=1; otherwise result=op1-op2 and neg=0.
  - `*`: W-cycle shift-add into a 2W-bit acc. Error if acc[2W-1:W]≠0.
  - On exit: go to DONE and pulse `result_valid`, or go to ERR on overflow with no pulse.
- DONE:
  - digit: op1=d, cnt=1, go to OP1 (starts a new calculation).
  - operator with neg=0 and result<10^DIGITS: op1=result, op2=0, cnt=0, go to OP2 (chaining).
  - operator with neg=1 or result≥10^DIGITS: ERR.
  - `=` or other: ignored.
- ERR:
  - digit: op1=d, cnt=1, clear error, go to OP1.
  - other keys: ignored.
- Esc in OP1, OP2, DONE or ERR: clear all registers and go to OP1.
- `disp_value`: op1 in OP1, op2 in OP2, op1 in CALC, result in DONE, 0 in ERR.
- `disp_neg` is 0 outside DONE.
- Operand arithmetic runs at W bits. op*10+d never overflows, because of the parameter rule.

## Timing
- Every byte is accepted on the edge where `scan_ready`=1. Register and output updates are visible the following cycle.
- Add/sub: `=` accepted at edge N, CALC for one cycle, DONE at edge N+1. `result_valid` is high for the cycle after N+1.
- Mul: CALC lasts exactly W cycles, so DONE/`result_valid` come at edge N+W. `busy` is high for exactly those W cycles.
- `result_valid` is never high for two consecutive cycles.
- Reset asserted in any state, including mid-multiply, returns to OP1 on the next edge. It clears `brk`, and all outputs go to 0.
- A `scan_ready` strobe on the same edge as `reset` is ignored.
- Back-to-back strobes on consecutive cycles are each processed; the design needs no inter-byte gap.

## Test plan
- Type 1,2,`+`,3,4,`=` → `disp_value`=46, `disp_neg`=0, `result_valid` one cycle, `busy` one cycle.
- Type 5,`-`,1,2,`=` → `disp_value`=7, `disp_neg`=1. Then `+` → ERR with `error`=1, `disp_value`=0.
- Type 1,2,`*`,1,1,`=` → `busy` for 8 cycles, then 132. Type 9,9,`*`,9,9,`=` → `error`=1, no `result_valid`.
- Type 7, then F0,3D (break), then `+`,2,`=` → 9; the break byte leaves op1=7. Byte E0 followed by 5A acts as `=`.
- Type 1,2,3 with DIGITS=2 → ERR. Then Esc → OP1, all zero. Then 4,`+`,5,`=` → 9. Then `+`,1,`=` → 10 (chaining).
- Start 9,9,`*`,2,`=`; assert `reset` at cycle 3 of CALC → next cycle state OP1, `busy`=0, all outputs 0, no `result_valid`.
